// File: rtl/fu_wb_arbiter.sv
// ---------------------------------------------------------------------------
// fu_wb_arbiter
//   Writeback stage between NB_SRC functional units and NB_WB shared
//   register-file writeback ports. Each source owns a DEPTH-entry completion
//   FIFO. A round-robin scan starting at rr_q grants up to NB_WB non-empty
//   FIFO heads per cycle. The j-th grant drives writeback port j and is
//   mirrored onto completion port j for the ROB.
//
// Ports
//   clk, rstn          clock, synchronous active-low reset
//   flush_i            discards buffered and incoming results, blocks retire
//   src_*_i / _o       per-source result bus with ready/valid handshake
//   wb_*_o             writeback ports (no backpressure)
//   cpl_*_o            completion ports, identical to wb valid/id
//   occupancy_o        per-source FIFO fill level
// ---------------------------------------------------------------------------

// Invariant checker, instantiated by fu_wb_arbiter.
module fu_wb_arbiter_chk #(
    parameter int NB_SRC = 4,
    parameter int NB_WB  = 2,
    parameter int DEPTH  = 2,
    parameter int ID_W   = 6,
    parameter int CW     = 2,
    parameter int SW     = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NB_SRC-1:0]        push_i,
    input  logic [NB_SRC-1:0]        ready_i,
    input  logic [NB_SRC*CW-1:0]     occ_i,
    input  logic [NB_WB*SW-1:0]      port_src_i,
    input  logic [NB_WB-1:0]         wb_valid_i,
    input  logic [NB_WB*ID_W-1:0]    wb_id_i,
    input  logic [NB_WB-1:0]         cpl_valid_i,
    input  logic [NB_WB*ID_W-1:0]    cpl_id_i
);
    // Sample all structural invariants once per cycle outside reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert ((push_i & ~ready_i) == '0);
            for (int s = 0; s < NB_SRC; s++) begin
                assert (occ_i[s*CW +: CW] <= CW'(DEPTH));
            end
            for (int a = 0; a < NB_WB; a++) begin
                for (int b = a + 1; b < NB_WB; b++) begin
                    assert (!(wb_valid_i[a] && wb_valid_i[b] &&
                              (port_src_i[a*SW +: SW] == port_src_i[b*SW +: SW])));
                end
            end
            assert (cpl_valid_i == wb_valid_i);
            assert (cpl_id_i == wb_id_i);
        end
    end
endmodule

module fu_wb_arbiter #(
    parameter int NB_SRC = 4,
    parameter int NB_WB  = 2,
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64,
    parameter int ID_W   = 6,
    parameter int RD_W   = 5
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               flush_i,
    input  logic [NB_SRC-1:0]                  src_valid_i,
    output logic [NB_SRC-1:0]                  src_ready_o,
    input  logic [NB_SRC*DATA_W-1:0]           src_data_i,
    input  logic [NB_SRC*ID_W-1:0]             src_id_i,
    input  logic [NB_SRC*RD_W-1:0]             src_rd_i,
    input  logic [NB_SRC-1:0]                  src_we_i,
    output logic [NB_WB-1:0]                   wb_valid_o,
    output logic [NB_WB*DATA_W-1:0]            wb_data_o,
    output logic [NB_WB*RD_W-1:0]              wb_rd_o,
    output logic [NB_WB-1:0]                   wb_we_o,
    output logic [NB_WB*ID_W-1:0]              wb_id_o,
    output logic [NB_WB-1:0]                   cpl_valid_o,
    output logic [NB_WB*ID_W-1:0]              cpl_id_o,
    output logic [NB_SRC*$clog2(DEPTH+1)-1:0]  occupancy_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(NB_SRC);
    localparam int GW = $clog2(NB_WB + 1);
    // Entry layout: {we, rd, id, data}
    localparam int EW = DATA_W + ID_W + RD_W + 1;

    logic [EW-1:0]     mem_q      [NB_SRC][DEPTH];
    logic [CW-1:0]     cnt_q      [NB_SRC];
    logic [CW-1:0]     cnt_d      [NB_SRC];
    logic [PW-1:0]     wptr_q     [NB_SRC];
    logic [PW-1:0]     wptr_d     [NB_SRC];
    logic [PW-1:0]     rptr_q     [NB_SRC];
    logic [PW-1:0]     rptr_d     [NB_SRC];
    logic [SW-1:0]     rr_q;
    logic [SW-1:0]     rr_d;

    logic [NB_SRC-1:0] push_s;
    logic [NB_SRC-1:0] pop_s;
    logic [NB_WB-1:0]  port_vld_s;
    logic [SW-1:0]     port_src_s [NB_WB];
    logic [EW-1:0]     head_s     [NB_WB];
    logic [SW:0]       scan_sum_s;
    logic [SW-1:0]     scan_idx_s;
    logic [SW-1:0]     last_src_s;
    logic [GW-1:0]     n_grant_s;
    logic [NB_WB*SW-1:0] port_src_flat_s;

    // Pointer advance with wrap at DEPTH (also correct for non-power-of-two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    // Ready from registered fill level only; a full FIFO stays not-ready while popping.
    always_comb begin
        src_ready_o = '0;
        for (int s = 0; s < NB_SRC; s++) begin
            if (flush_i) begin
                src_ready_o[s] = 1'b0;
            end else if (cnt_q[s] < CW'(DEPTH)) begin
                src_ready_o[s] = 1'b1;
            end else begin
                src_ready_o[s] = 1'b0;
            end
        end
    end

    assign push_s = src_valid_i & src_ready_o;

    // Round-robin scan from rr_q; the j-th non-empty source found is bound to port j.
    always_comb begin
        port_vld_s = '0;
        pop_s      = '0;
        scan_sum_s = '0;
        scan_idx_s = '0;
        n_grant_s  = '0;
        last_src_s = rr_q;
        for (int k = 0; k < NB_WB; k++) begin
            port_src_s[k] = '0;
        end
        for (int i = 0; i < NB_SRC; i++) begin
            scan_sum_s = {1'b0, rr_q} + (SW+1)'(i);
            if (scan_sum_s >= (SW+1)'(NB_SRC)) begin
                scan_sum_s = scan_sum_s - (SW+1)'(NB_SRC);
            end else begin
                scan_sum_s = scan_sum_s;
            end
            scan_idx_s = scan_sum_s[SW-1:0];
            if (!flush_i && (cnt_q[scan_idx_s] != '0) && (n_grant_s < GW'(NB_WB))) begin
                for (int k = 0; k < NB_WB; k++) begin
                    if (n_grant_s == GW'(k)) begin
                        port_vld_s[k] = 1'b1;
                        port_src_s[k] = scan_idx_s;
                    end else begin
                        port_vld_s[k] = port_vld_s[k];
                    end
                end
                pop_s[scan_idx_s] = 1'b1;
                last_src_s        = scan_idx_s;
                n_grant_s         = n_grant_s + GW'(1);
            end else begin
                n_grant_s = n_grant_s;
            end
        end
        // Resume the next scan just past the last winner.
        if (n_grant_s != '0) begin
            if (last_src_s == SW'(NB_SRC - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = last_src_s + SW'(1);
            end
        end else begin
            rr_d = rr_q;
        end
    end

    // Per-source FIFO pointer and count next state.
    always_comb begin
        for (int s = 0; s < NB_SRC; s++) begin
            wptr_d[s] = wptr_q[s];
            rptr_d[s] = rptr_q[s];
            cnt_d[s]  = cnt_q[s];
            if (push_s[s]) begin
                wptr_d[s] = ptr_inc(wptr_q[s]);
            end else begin
                wptr_d[s] = wptr_q[s];
            end
            if (pop_s[s]) begin
                rptr_d[s] = ptr_inc(rptr_q[s]);
            end else begin
                rptr_d[s] = rptr_q[s];
            end
            if (push_s[s] && !pop_s[s]) begin
                cnt_d[s] = cnt_q[s] + CW'(1);
            end else if (!push_s[s] && pop_s[s]) begin
                cnt_d[s] = cnt_q[s] - CW'(1);
            end else begin
                cnt_d[s] = cnt_q[s];
            end
        end
    end

    // Control state: reset clears everything, flush empties FIFOs but keeps rr_q.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int s = 0; s < NB_SRC; s++) begin
                cnt_q[s]  <= '0;
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
            end
            rr_q <= '0;
        end else if (flush_i) begin
            for (int s = 0; s < NB_SRC; s++) begin
                cnt_q[s]  <= '0;
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
            end
            rr_q <= rr_q;
        end else begin
            for (int s = 0; s < NB_SRC; s++) begin
                cnt_q[s]  <= cnt_d[s];
                wptr_q[s] <= wptr_d[s];
                rptr_q[s] <= rptr_d[s];
            end
            rr_q <= rr_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NB_SRC; s++) begin
            if (push_s[s]) begin
                mem_q[s][wptr_q[s]] <= {src_we_i[s],
                                        src_rd_i[s*RD_W +: RD_W],
                                        src_id_i[s*ID_W +: ID_W],
                                        src_data_i[s*DATA_W +: DATA_W]};
            end
        end
    end

    // Writeback ports straight from granted heads; invalid ports drive zeros.
    always_comb begin
        wb_valid_o = port_vld_s;
        wb_data_o  = '0;
        wb_rd_o    = '0;
        wb_we_o    = '0;
        wb_id_o    = '0;
        for (int k = 0; k < NB_WB; k++) begin
            head_s[k] = mem_q[port_src_s[k]][rptr_q[port_src_s[k]]];
            if (port_vld_s[k]) begin
                wb_data_o[k*DATA_W +: DATA_W] = head_s[k][DATA_W-1:0];
                wb_id_o[k*ID_W +: ID_W]       = head_s[k][DATA_W +: ID_W];
                wb_rd_o[k*RD_W +: RD_W]       = head_s[k][DATA_W+ID_W +: RD_W];
                wb_we_o[k]                    = head_s[k][EW-1];
            end else begin
                wb_we_o[k] = 1'b0;
            end
        end
    end

    assign cpl_valid_o = wb_valid_o;
    assign cpl_id_o    = wb_id_o;

    // Flatten fill levels and port sources for the occupancy port and checker.
    always_comb begin
        occupancy_o     = '0;
        port_src_flat_s = '0;
        for (int s = 0; s < NB_SRC; s++) begin
            occupancy_o[s*CW +: CW] = cnt_q[s];
        end
        for (int k = 0; k < NB_WB; k++) begin
            port_src_flat_s[k*SW +: SW] = port_src_s[k];
        end
    end

    fu_wb_arbiter_chk #(
        .NB_SRC (NB_SRC),
        .NB_WB  (NB_WB),
        .DEPTH  (DEPTH),
        .ID_W   (ID_W),
        .CW     (CW),
        .SW     (SW)
    ) u_chk (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (push_s),
        .ready_i     (src_ready_o),
        .occ_i       (occupancy_o),
        .port_src_i  (port_src_flat_s),
        .wb_valid_i  (wb_valid_o),
        .wb_id_i     (wb_id_o),
        .cpl_valid_i (cpl_valid_o),
        .cpl_id_i    (cpl_id_o)
    );
endmodule

// File: doc/fu_wb_arbiter.md
Name: fu_wb_arbiter

Overview:
Parametrised writeback stage between NB_SRC functional units and NB_WB shared register-file writeback ports. It replaces the fixed one-FU-per-port wiring. Each FU result enters a per-source completion buffer (FIFO). Every cycle a round-robin arbiter drains up to NB_WB buffer heads onto the writeback ports and mirrors each grant onto a completion port for the ROB. FUs see ready/valid backpressure; writeback ports have none.

Parameters:
NB_SRC, 4, number of FU result sources (at least 2)
NB_WB, 2, number of writeback/completion ports (at least 1, at most NB_SRC)
DEPTH, 2, entries per source completion buffer (at least 1)
DATA_W, 64, result data width
ID_W, 6, ROB id width
RD_W, 5, destination register index width

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
flush_i  in  1  pipeline flush; discards all buffered and incoming results
src_valid_i  in  NB_SRC  result valid per source
src_ready_o  out  NB_SRC  buffer can accept, per source
src_data_i  in  NB_SRC*DATA_W  result data; source s occupies bits [s*DATA_W +: DATA_W]
src_id_i  in  NB_SRC*ID_W  ROB id per source
src_rd_i  in  NB_SRC*RD_W  destination register per source
src_we_i  in  NB_SRC  register write enable per source (0 means completion only, e.g. branch)
wb_valid_o  out  NB_WB  writeback port valid
wb_data_o  out  NB_WB*DATA_W  writeback data
wb_rd_o  out  NB_WB*RD_W  writeback destination
wb_we_o  out  NB_WB  register-file write enable (equals wb_valid_o[k] AND the entry's we)
wb_id_o  out  NB_WB*ID_W  ROB id of the writeback
cpl_valid_o  out  NB_WB  completion valid; equals wb_valid_o
cpl_id_o  out  NB_WB*ID_W  completion id; equals wb_id_o
occupancy_o  out  NB_SRC*$clog2(DEPTH+1)  per-source buffer fill level (debug/perf)

Behaviour:
- Clock and reset: single clock clk. Reset rstn is synchronous and active-low. During reset all buffers are emptied, every count is 0, the round-robin pointer is 0, all wb_*/cpl_* valids are 0, and src_ready_o is all-ones from the first cycle after reset.
- Accept: a result is accepted when src_valid_i[s] and src_ready_o[s] are both 1.
  - src_ready_o[s] = (count[s] < DEPTH) and not flush_i.
  - It does not depend on same-cycle pops: a full buffer stays not-ready even while popping.
  - src_ready_o depends only on registered state and flush_i, never on src_valid_i.
- Latency: a result accepted in cycle N can appear on a writeback port no earlier than cycle N+1. There is no combinational input-to-output bypass.
- Arbitration, combinational from buffer heads:
  - Scan sources in order rr_ptr, rr_ptr+1, ..., wrapping mod NB_SRC.
  - The first up to NB_WB non-empty sources are granted.
  - The j-th granted source drives port j; ports j from the number of grants up to NB_WB-1 are invalid.
  - A granted head pops at the clock edge.
- Pointer update:
  - If at least one grant is made, rr_ptr <= (index of the last granted source + 1) mod NB_SRC.
  - Otherwise rr_ptr holds.
  - This guarantees starvation freedom: any non-empty source is granted within ceil(NB_SRC/NB_WB) cycles.
- Outputs: wb_*/cpl_* are driven combinationally from buffer heads and are valid in the same cycle as the grant. Data, rd and id of invalid ports are driven to 0.
- Simultaneous push and pop on the same source, non-full: count is unchanged and FIFO order is preserved. DEPTH=1 behaves as a plain register with no pass-through.
- Order: within a source, results leave in FIFO order. No ordering is guaranteed across sources.
- Flush:
  - flush_i=1 forces all wb/cpl valids to 0 in that cycle (nothing retires).
  - All counts are cleared at the edge and incoming results are dropped (src_ready_o=0).
  - rr_ptr is preserved.
- Reset mid-operation: identical to the reset state above; buffered results are lost.
- Widths: counts are $clog2(DEPTH+1) bits. Read and write pointers are $clog2(DEPTH) bits (1 bit when DEPTH=1) and wrap at DEPTH, including non-power-of-two DEPTH.
- Assertions:
  - No push when not ready.
  - Count never exceeds DEPTH.
  - No two ports carry the same source in a cycle.
  - cpl == wb every cycle.

Test Plan:
1. Reset, then NB_SRC=4, NB_WB=2: source 1 pushes id=5, data=0xAB, rd=3, we=1 in cycle 0 -> cycle 1: wb_valid_o=2'b01, wb_id_o[0]=5, wb_data_o[0]=0xAB, wb_we_o[0]=1; cycle 2: no valid ports.
2. All four sources push once in the same cycle with rr_ptr=0 -> next cycle ports carry sources 0 and 1; the following cycle carry sources 2 and 3; rr_ptr ends at 0.
3. Fairness: sources 0 and 3 saturated, NB_WB=1, rr_ptr=0 -> grants alternate 0, 3, 0, 3; no source waits more than 2 cycles.
4. DEPTH=2 backpressure: source 2 pushes 3 back-to-back results while a lower-index-priority flood blocks its grants -> src_ready_o[2]=0 after 2 accepts; the 3rd is held by the FU; ids drain in push order once granted.
5. src_we_i=0 for a branch id=9 -> cpl_valid_o=1, cpl_id_o=9, wb_we_o=0 on that port.
6. flush_i with 3 entries buffered and a same-cycle push -> no valid outputs that cycle; next cycle all occupancies are 0 and the dropped push never appears. Repeat with rstn low mid-traffic -> same empty state, rr_ptr=0.
